// File: rtl/qspi_sram_responder.sv
// SQI serial-SRAM responder (23LC1024-style) with a backdoor port, oversampling SCK/CS_N on clk.
// Optional single-bit SPI power-up mode with EQIO/RSTIO switching: QSPI_RSP_SPI_MODE_EN.
module qspi_sram_responder #(
    parameter int unsigned ADDR_WIDTH    = 10,
    parameter int unsigned DUMMY_NIBBLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cs_n,
    input  logic                  sck,
    input  logic [3:0]            sio_i,
    output logic [3:0]            sio_o,
    output logic                  sio_oe,
    input  logic                  bd_we,
    input  logic [ADDR_WIDTH-1:0] bd_addr,
    input  logic [7:0]            bd_wdata,
    output logic [7:0]            bd_rdata,
    output logic                  cmd_err
);

    localparam int unsigned ShW   = (ADDR_WIDTH > 8) ? ADDR_WIDTH : 8;
    localparam int unsigned Depth = 1 << ADDR_WIDTH;

    typedef enum logic [2:0] {
        StIdle, StCmd, StAddr, StDummy, StRdata, StWdata, StIgnore
    } state_e;

    logic [7:0]            mem [Depth];
    logic [2:0]            cs_sync_q, sck_sync_q;
    logic [3:0]            sio_s1_q, sio_s2_q;
    state_e                state_q, state_d;
    logic [4:0]            cnt_q, cnt_d;
    logic [ShW-1:0]        sh_q, sh_d, sh_in;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  wr_q, wr_d;
    logic [3:0]            sio_o_q, sio_o_d;
    logic                  sio_oe_q, sio_oe_d;
    logic                  cmd_err_q, cmd_err_d;
    logic [7:0]            bd_rdata_q;
    logic                  ser_we;
    logic [7:0]            rd_sh;
    logic                  cs_s, cs_fall, cs_rise, sck_rise, sck_fall;
    logic [4:0]            cmd_last, addr_last, byte_last;
    logic                  spi;

`ifdef QSPI_RSP_SPI_MODE_EN
    logic spi_q, spi_d, spi_next_q, spi_next_d;
    assign spi = spi_q;
`else
    assign spi = 1'b0;
`endif

    assign cs_s     = cs_sync_q[1];
    assign cs_fall  = cs_sync_q[2] & ~cs_s;
    assign cs_rise  = ~cs_sync_q[2] & cs_s;
    // SCK activity only counts while the chip is selected
    assign sck_rise = ~cs_s & ~sck_sync_q[2] & sck_sync_q[1];
    assign sck_fall = ~cs_s & sck_sync_q[2] & ~sck_sync_q[1];

    assign cmd_last  = spi ? 5'd7 : 5'd1;
    assign addr_last = spi ? 5'd23 : 5'd5;
    assign byte_last = spi ? 5'd7 : 5'd1;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sh_d      = sh_q;
        addr_d    = addr_q;
        wr_d      = wr_q;
        sio_o_d   = sio_o_q;
        sio_oe_d  = sio_oe_q;
        cmd_err_d = cmd_err_q;
        ser_we    = 1'b0;
`ifdef QSPI_RSP_SPI_MODE_EN
        spi_d      = spi_q;
        spi_next_d = spi_next_q;
`endif
        sh_in = spi ? ShW'({sh_q, sio_s2_q[0]}) : ShW'({sh_q, sio_s2_q});
        rd_sh = mem[addr_q] << (spi ? cnt_q[2:0] : {cnt_q[0], 2'b00});

        if (cs_rise) begin
            state_d  = StIdle;
            cnt_d    = '0;
            sio_oe_d = 1'b0;
            sio_o_d  = '0;
        end else if (cs_fall) begin
            state_d  = StCmd;
            cnt_d    = '0;
            sio_oe_d = 1'b0;
`ifdef QSPI_RSP_SPI_MODE_EN
            spi_d = spi_next_q;
`endif
        end else begin
            unique case (state_q)
                StCmd: if (sck_rise) begin
                    sh_d = sh_in;
                    if (cnt_q == cmd_last) begin
                        cnt_d = '0;
                        if (sh_in[7:0] == 8'h03) begin
                            state_d = StAddr;
                            wr_d    = 1'b0;
                        end else if (sh_in[7:0] == 8'h02) begin
                            state_d = StAddr;
                            wr_d    = 1'b1;
`ifdef QSPI_RSP_SPI_MODE_EN
                        end else if (spi && sh_in[7:0] == 8'h38) begin
                            state_d    = StIgnore;
                            spi_next_d = 1'b0;
                        end else if (!spi && sh_in[7:0] == 8'hFF) begin
                            state_d    = StIgnore;
                            spi_next_d = 1'b1;
`endif
                        end else begin
                            state_d   = StIgnore;
                            cmd_err_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
                StAddr: if (sck_rise) begin
                    sh_d = sh_in;
                    if (cnt_q == addr_last) begin
                        cnt_d  = '0;
                        addr_d = sh_in[ADDR_WIDTH-1:0];
                        if (wr_q) state_d = StWdata;
                        else if (spi || DUMMY_NIBBLES == 0) state_d = StRdata;
                        else state_d = StDummy;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
                StDummy: if (sck_rise) begin
                    if (cnt_q == 5'(DUMMY_NIBBLES - 1)) begin
                        cnt_d   = '0;
                        state_d = StRdata;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
                StRdata: if (sck_fall) begin
                    sio_oe_d = 1'b1;
                    sio_o_d  = spi ? {2'b00, rd_sh[7], 1'b0} : rd_sh[7:4];
                    if (cnt_q == byte_last) begin
                        cnt_d  = '0;
                        addr_d = addr_q + ADDR_WIDTH'(1);
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
                StWdata: if (sck_rise) begin
                    sh_d = sh_in;
                    if (cnt_q == byte_last) begin
                        ser_we = 1'b1;
                        cnt_d  = '0;
                        addr_d = addr_q + ADDR_WIDTH'(1);
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
                StIdle, StIgnore: ;
                default: state_d = StIdle;
            endcase
        end
    end

    // Synchronisers are left unreset so a held CS_N cannot fake an edge when reset releases
    always_ff @(posedge clk) begin
        cs_sync_q  <= {cs_sync_q[1:0], cs_n};
        sck_sync_q <= {sck_sync_q[1:0], sck};
        sio_s1_q   <= sio_i;
        sio_s2_q   <= sio_s1_q;
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            sh_q       <= '0;
            addr_q     <= '0;
            wr_q       <= 1'b0;
            sio_o_q    <= '0;
            sio_oe_q   <= 1'b0;
            cmd_err_q  <= 1'b0;
            bd_rdata_q <= '0;
`ifdef QSPI_RSP_SPI_MODE_EN
            spi_q      <= 1'b1;
            spi_next_q <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sh_q       <= sh_d;
            addr_q     <= addr_d;
            wr_q       <= wr_d;
            sio_o_q    <= sio_o_d;
            sio_oe_q   <= sio_oe_d;
            cmd_err_q  <= cmd_err_d;
            bd_rdata_q <= mem[bd_addr];
`ifdef QSPI_RSP_SPI_MODE_EN
            spi_q      <= spi_d;
            spi_next_q <= spi_next_d;
`endif
        end
    end

    // Backdoor write has priority when both ports hit the same byte
    always_ff @(posedge clk) begin
        if (ser_we && !(bd_we && bd_addr == addr_q)) mem[addr_q] <= sh_in[7:0];
        if (bd_we) mem[bd_addr] <= bd_wdata;
    end

    assign sio_o    = sio_o_q;
    assign sio_oe   = sio_oe_q;
    assign bd_rdata = bd_rdata_q;
    assign cmd_err  = cmd_err_q;

endmodule

// File: tb/tb_qspi_sram_responder.sv
// Directed bench for qspi_sram_responder: table of quad transactions plus hand-written corner cases.
module tb_qspi_sram_responder;

    localparam int AW    = 10;
    localparam int DUMMY = 2;
    localparam int HALF  = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic          cs_n, sck;
    logic [3:0]    sio_i, sio_o;
    logic          sio_oe;
    logic          bd_we;
    logic [AW-1:0] bd_addr;
    logic [7:0]    bd_wdata, bd_rdata;
    logic          cmd_err;

    int passed = 0;
    int total  = 0;
    int oe_cycles = 0;

    qspi_sram_responder #(.ADDR_WIDTH(AW), .DUMMY_NIBBLES(DUMMY)) dut (
        .clk(clk), .reset(reset), .cs_n(cs_n), .sck(sck), .sio_i(sio_i), .sio_o(sio_o),
        .sio_oe(sio_oe), .bd_we(bd_we), .bd_addr(bd_addr), .bd_wdata(bd_wdata),
        .bd_rdata(bd_rdata), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (sio_oe === 1'b1) oe_cycles <= oe_cycles + 1;

    initial begin
        #500us;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1);
    end

    typedef struct {
        logic             is_wr;
        logic [23:0]      addr;
        int               n;
        logic [2:0][7:0]  data;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s: got %0h, required %0h", name, got, exp);
        else passed++;
    endtask

    task automatic half_phase();
        repeat (HALF) @(posedge clk);
        #1;
    endtask

    task automatic quad_nib(input logic [3:0] n);
        sio_i = n;
        half_phase();
        sck = 1'b1;
        half_phase();
        sck = 1'b0;
    endtask

    task automatic quad_byte(input logic [7:0] b);
        quad_nib(b[7:4]);
        quad_nib(b[3:0]);
    endtask

    task automatic quad_hdr(input logic [7:0] cmd, input logic [23:0] addr);
        quad_byte(cmd);
        quad_byte(addr[23:16]);
        quad_byte(addr[15:8]);
        quad_byte(addr[7:0]);
    endtask

    task automatic quad_read_byte(output logic [7:0] b, inout logic oe_ok);
        b = '0;
        for (int k = 0; k < 2; k++) begin
            sio_i = '0;
            half_phase();
            b = {b[3:0], sio_o};
            oe_ok = oe_ok & (sio_oe === 1'b1);
            sck = 1'b1;
            half_phase();
            sck = 1'b0;
        end
    endtask

    task automatic cs_start();
        cs_n = 1'b0;
        half_phase();
    endtask

    task automatic cs_end();
        half_phase();
        cs_n = 1'b1;
        half_phase();
        half_phase();
    endtask

    task automatic qread(input logic [23:0] addr, input int n, output logic [2:0][7:0] got,
                         output logic oe_ok);
        logic [7:0] b;
        got = '0;
        oe_ok = 1'b1;
        cs_start();
        quad_hdr(8'h03, addr);
        repeat (DUMMY) quad_nib(4'h0);
        for (int i = 0; i < n; i++) begin
            quad_read_byte(b, oe_ok);
            got[i] = b;
        end
        cs_end();
    endtask

    task automatic bd_read(input logic [AW-1:0] a, output logic [7:0] d);
        bd_addr = a;
        @(posedge clk);
        #1;
        d = bd_rdata;
    endtask

    task automatic bd_write(input logic [AW-1:0] a, input logic [7:0] d);
        bd_addr  = a;
        bd_wdata = d;
        bd_we    = 1'b1;
        @(posedge clk);
        #1;
        bd_we = 1'b0;
    endtask

`ifdef QSPI_RSP_SPI_MODE_EN
    task automatic spi_byte(input logic [7:0] b);
        for (int k = 7; k >= 0; k--) begin
            sio_i = {3'b000, b[k]};
            half_phase();
            sck = 1'b1;
            half_phase();
            sck = 1'b0;
        end
    endtask

    task automatic spi_read_byte(output logic [7:0] b, inout logic oe_ok);
        b = '0;
        for (int k = 0; k < 8; k++) begin
            sio_i = '0;
            half_phase();
            b = {b[6:0], sio_o[1]};
            oe_ok = oe_ok & (sio_oe === 1'b1);
            sck = 1'b1;
            half_phase();
            sck = 1'b0;
        end
    endtask
`endif

    // Leaves the device in quad mode regardless of build
    task automatic enter_quad();
`ifdef QSPI_RSP_SPI_MODE_EN
        cs_start();
        spi_byte(8'h38);
        cs_end();
`endif
    endtask

    vec_t            vecs [7];
    logic [7:0]      rd;
    logic [2:0][7:0] got;
    logic            oe_ok;
    int              oe_before;

    initial begin
        vecs[0] = '{1'b0, 24'h000010, 1, {8'h00, 8'h00, 8'hA5}};
        vecs[1] = '{1'b1, 24'h000020, 3, {8'h56, 8'h34, 8'h12}};
        vecs[2] = '{1'b0, 24'h0003FF, 2, {8'h00, 8'h11, 8'hEE}};
        vecs[3] = '{1'b0, 24'h000020, 3, {8'h56, 8'h34, 8'h12}};
        vecs[4] = '{1'b0, 24'hFFF010, 1, {8'h00, 8'h00, 8'hA5}};
        vecs[5] = '{1'b1, 24'h0003FF, 2, {8'h00, 8'hBC, 8'h9A}};
        vecs[6] = '{1'b0, 24'h0003FF, 2, {8'h00, 8'hBC, 8'h9A}};

        reset = 1'b1; cs_n = 1'b1; sck = 1'b0; sio_i = '0;
        bd_we = 1'b0; bd_addr = '0; bd_wdata = '0;
        repeat (5) @(posedge clk);
        #1;
        check("reset_sio_o", 32'(sio_o), 32'h0);
        check("reset_sio_oe", 32'(sio_oe), 32'h0);
        check("reset_cmd_err", 32'(cmd_err), 32'h0);
        check("reset_bd_rdata", 32'(bd_rdata), 32'h0);
        reset = 1'b0;

        bd_write(10'h010, 8'hA5);
        bd_write(10'h3FF, 8'hEE);
        bd_write(10'h000, 8'h11);
        bd_write(10'h030, 8'h00);
        bd_write(10'h031, 8'h77);
        bd_read(10'h010, rd);
        check("bd_read_010", 32'(rd), 32'hA5);

`ifdef QSPI_RSP_SPI_MODE_EN
        oe_ok = 1'b1;
        cs_start();
        spi_byte(8'h03); spi_byte(8'h00); spi_byte(8'h00); spi_byte(8'h10);
        spi_read_byte(rd, oe_ok);
        cs_end();
        check("spi_read_010", 32'(rd), 32'hA5);
        check("spi_read_oe", 32'(oe_ok), 32'h1);
`endif
        enter_quad();

        for (int v = 0; v < 7; v++) begin
            if (vecs[v].is_wr) begin
                oe_before = oe_cycles;
                cs_start();
                quad_hdr(8'h02, vecs[v].addr);
                for (int i = 0; i < vecs[v].n; i++) quad_byte(vecs[v].data[i]);
                cs_end();
                check($sformatf("vec%0d_wr_oe_cycles", v), 32'(oe_cycles - oe_before), 32'h0);
                for (int i = 0; i < vecs[v].n; i++) begin
                    bd_read(AW'(vecs[v].addr[AW-1:0] + AW'(i)), rd);
                    check($sformatf("vec%0d_wr_byte%0d", v, i), 32'(rd), 32'(vecs[v].data[i]));
                end
            end else begin
                qread(vecs[v].addr, vecs[v].n, got, oe_ok);
                for (int i = 0; i < vecs[v].n; i++)
                    check($sformatf("vec%0d_rd_byte%0d", v, i), 32'(got[i]), 32'(vecs[v].data[i]));
                check($sformatf("vec%0d_rd_oe", v), 32'(oe_ok), 32'h1);
            end
        end

        // Partial write: only the completed byte lands
        cs_start();
        quad_hdr(8'h02, 24'h000030);
        quad_nib(4'hB); quad_nib(4'hC); quad_nib(4'hD);
        cs_end();
        bd_read(10'h030, rd);
        check("partial_wr_030", 32'(rd), 32'hBC);
        bd_read(10'h031, rd);
        check("partial_wr_031_kept", 32'(rd), 32'h77);
        qread(24'h000010, 1, got, oe_ok);
        check("after_partial_read", 32'(got[0]), 32'hA5);

        // CS_N rising mid-read releases the bus within 3 clocks
        cs_start();
        quad_hdr(8'h03, 24'h000010);
        repeat (DUMMY) quad_nib(4'h0);
        half_phase();
        check("midread_oe_on", 32'(sio_oe), 32'h1);
        check("midread_hi_nibble", 32'(sio_o), 32'hA);
        sck = 1'b1;
        half_phase();
        cs_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("cs_rise_oe_off", 32'(sio_oe), 32'h0);
        sck = 1'b0;
        half_phase(); half_phase();

        // Unsupported command
        oe_before = oe_cycles;
        cs_start();
        quad_byte(8'h9F);
        quad_byte(8'h00); quad_byte(8'h00); quad_byte(8'h10);
        repeat (4) quad_nib(4'h0);
        cs_end();
        check("bad_cmd_oe_cycles", 32'(oe_cycles - oe_before), 32'h0);
        check("bad_cmd_err_set", 32'(cmd_err), 32'h1);
        qread(24'h000010, 1, got, oe_ok);
        check("bad_cmd_next_read", 32'(got[0]), 32'hA5);
        check("bad_cmd_err_sticky", 32'(cmd_err), 32'h1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("bad_cmd_err_cleared", 32'(cmd_err), 32'h0);
        enter_quad();

        // Reset mid-read: bus released at once, memory intact
        cs_start();
        quad_hdr(8'h03, 24'h000010);
        repeat (DUMMY) quad_nib(4'h0);
        half_phase();
        check("pre_reset_oe_on", 32'(sio_oe), 32'h1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("reset_midread_oe", 32'(sio_oe), 32'h0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        sck = 1'b1; half_phase(); sck = 1'b0; half_phase();
        check("post_reset_oe_off", 32'(sio_oe), 32'h0);
        cs_n = 1'b1;
        half_phase(); half_phase();
        bd_read(10'h010, rd);
        check("reset_mem_kept", 32'(rd), 32'hA5);
        enter_quad();
        qread(24'h000010, 1, got, oe_ok);
        check("post_reset_read", 32'(got[0]), 32'hA5);
        check("post_reset_read_oe", 32'(oe_ok), 32'h1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
